// File: rtl/exclusive_gate.sv
// rtl/exclusive_gate.sv - registered XOR/XNOR unit with parity, Hamming distance and equality outputs
module exclusive_gate #(
    parameter int WIDTH = 1,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] xor_out,
    output logic [WIDTH-1:0] xnor_out,
    output logic             parity_out,
    output logic [CNT_W-1:0] hamming_out,
    output logic             equal_out,
    output logic             out_valid
);

    logic [WIDTH-1:0] xor_q, xor_d;
    logic [WIDTH-1:0] xnor_q, xnor_d;
    logic             parity_q, parity_d;
    logic [CNT_W-1:0] hamming_q, hamming_d;
    logic             equal_q, equal_d;
    logic             valid_q, valid_d;

    logic [WIDTH-1:0] diff;
    logic [CNT_W-1:0] ham_sum;

    always_comb begin
        diff    = a ^ b;
        ham_sum = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ham_sum = ham_sum + CNT_W'(diff[i]);
        end
    end

    // Operands are only looked at when in_valid is high, so unknown a/b while idle never reach state.
    always_comb begin
        xor_d     = xor_q;
        xnor_d    = xnor_q;
        parity_d  = parity_q;
        hamming_d = hamming_q;
        equal_d   = equal_q;
        valid_d   = in_valid;
        if (in_valid) begin
            xor_d     = diff;
            xnor_d    = ~diff;
            parity_d  = ^diff;
            hamming_d = ham_sum;
            equal_d   = (diff == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xor_q     <= '0;
            xnor_q    <= '0;
            parity_q  <= 1'b0;
            hamming_q <= '0;
            equal_q   <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            xor_q     <= xor_d;
            xnor_q    <= xnor_d;
            parity_q  <= parity_d;
            hamming_q <= hamming_d;
            equal_q   <= equal_d;
            valid_q   <= valid_d;
        end
    end

    assign xor_out     = xor_q;
    assign xnor_out    = xnor_q;
    assign parity_out  = parity_q;
    assign hamming_out = hamming_q;
    assign equal_out   = equal_q;
    assign out_valid   = valid_q;

endmodule

// File: tb/tb_exclusive_gate.sv
// tb/tb_exclusive_gate.sv - scoreboard bench for exclusive_gate at WIDTH=1 and WIDTH=8
module tb_exclusive_gate;

    typedef struct {
        logic [7:0] x;
        logic [7:0] xn;
        logic       p;
        logic [3:0] h;
        logic       e;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;

    logic       x1, xn1, p1, h1, e1, v1;
    logic [7:0] x8, xn8;
    logic [3:0] h8;
    logic       p8, e8, v8;

    int n_total = 0;
    int n_pass  = 0;

    res_t q1[$];
    res_t q8[$];
    res_t last1, last8, zero_res;

    always #5 clk = ~clk;

    exclusive_gate #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a8[0]), .b(b8[0]),
        .xor_out(x1), .xnor_out(xn1), .parity_out(p1), .hamming_out(h1),
        .equal_out(e1), .out_valid(v1)
    );

    exclusive_gate #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a8), .b(b8),
        .xor_out(x8), .xnor_out(xn8), .parity_out(p8), .hamming_out(h8),
        .equal_out(e8), .out_valid(v8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    // Reference: walk the bits, count the ones that disagree.
    function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input int w);
        res_t r;
        int   cnt = 0;
        r.x  = '0;
        r.xn = '0;
        for (int i = 0; i < w; i++) begin
            if (a[i] != b[i]) begin
                cnt++;
                r.x[i] = 1'b1;
            end else begin
                r.xn[i] = 1'b1;
            end
        end
        r.p = (cnt % 2) == 1;
        r.h = 4'(cnt);
        r.e = (cnt == 0);
        return r;
    endfunction

    task automatic cmp1(input string tag, input res_t e);
        chk({tag, "_w1_xor"},  64'(x1),  64'(e.x[0]));
        chk({tag, "_w1_xnor"}, 64'(xn1), 64'(e.xn[0]));
        chk({tag, "_w1_par"},  64'(p1),  64'(e.p));
        chk({tag, "_w1_ham"},  64'(h1),  64'(e.h));
        chk({tag, "_w1_eq"},   64'(e1),  64'(e.e));
    endtask

    task automatic cmp8(input string tag, input res_t e);
        chk({tag, "_w8_xor"},  64'(x8),  64'(e.x));
        chk({tag, "_w8_xnor"}, 64'(xn8), 64'(e.xn));
        chk({tag, "_w8_par"},  64'(p8),  64'(e.p));
        chk({tag, "_w8_ham"},  64'(h8),  64'(e.h));
        chk({tag, "_w8_eq"},   64'(e8),  64'(e.e));
    endtask

    task automatic check_all_zero(input string tag);
        cmp1(tag, zero_res);
        cmp8(tag, zero_res);
        chk({tag, "_w1_valid"}, 64'(v1), 64'd0);
        chk({tag, "_w8_valid"}, 64'(v8), 64'd0);
    endtask

    // Monitor: a valid output pops the next expected result; an idle cycle must hold the last one.
    always @(negedge clk) begin
        if (rst_n) begin
            if (v1) begin
                if (q1.size() == 0) chk("w1_unexpected_valid", 64'd1, 64'd0);
                else begin
                    last1 = q1.pop_front();
                    cmp1("res", last1);
                end
            end else begin
                cmp1("hold", last1);
            end
            if (v8) begin
                if (q8.size() == 0) chk("w8_unexpected_valid", 64'd1, 64'd0);
                else begin
                    last8 = q8.pop_front();
                    cmp8("res", last8);
                end
            end else begin
                cmp8("hold", last8);
            end
        end
    end

    task automatic op(input logic v, input logic [7:0] a, input logic [7:0] b);
        @(posedge clk);
        #2;
        in_valid = v;
        a8 = a;
        b8 = b;
        if (v) begin
            q1.push_back(model(a, b, 1));
            q8.push_back(model(a, b, 8));
        end
    endtask

    initial begin
        zero_res = '{x: '0, xn: '0, p: 1'b0, h: '0, e: 1'b0};
        last1 = zero_res;
        last8 = zero_res;

        #1;
        check_all_zero("reset0");
        #2;
        rst_n = 1'b1;

        op(1'b0, 8'h00, 8'h00);
        op(1'b1, 8'h00, 8'h00);
        op(1'b1, 8'h00, 8'h01);
        op(1'b1, 8'h01, 8'h00);
        op(1'b1, 8'h01, 8'h01);
        op(1'b1, 8'hA5, 8'h0F);
        op(1'b1, 8'h3C, 8'h3C);
        op(1'b0, 8'($urandom), 8'($urandom));
        op(1'b0, 8'($urandom), 8'($urandom));
        op(1'b1, 8'hFF, 8'h00);
        op(1'b1, 8'h01, 8'h00);
        op(1'b0, 8'h00, 8'h00);

        for (int i = 0; i < 300; i++) begin
            op($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom));
        end

        // Pulse reset between clock edges while ops are streaming.
        op(1'b1, 8'h5A, 8'hC3);
        op(1'b1, 8'h12, 8'h34);
        #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check_all_zero("midreset");
        q1.delete();
        q8.delete();
        last1 = zero_res;
        last8 = zero_res;
        #1;
        rst_n = 1'b1;

        op(1'b0, 8'($urandom), 8'($urandom));
        op(1'b0, 8'($urandom), 8'($urandom));
        op(1'b1, 8'hF0, 8'h0E);
        for (int i = 0; i < 100; i++) begin
            op($urandom_range(0, 1) != 0, 8'($urandom), 8'($urandom));
        end
        op(1'b0, 8'h00, 8'h00);
        op(1'b0, 8'h00, 8'h00);
        @(negedge clk);
        #1;
        chk("w1_queue_drained", 64'(q1.size()), 64'd0);
        chk("w8_queue_drained", 64'(q8.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
